sram_bus_tester: RTL and testbench

- Parametrised board-level exerciser for the SRAM interface pins and their transceivers. Sits between `top` and the data, address and control pin buses.
- Drive modes (walking-one, walking-zero, binary count) step patterns at a programmable dwell rate and check a loopback fixture.
- Monitor mode samples the buses with the transceivers set to receive and accumulates per-pin toggle coverage.
- Results are shown on the 8 board LEDs.

---
 rtl/sram_bus_tester.sv | 209 ++++++++++++++++++++
 tb/tb_sram_bus_tester.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_tester.sv
// Board-level exerciser for the SRAM data/address/control pins.
// Drive modes step walking-one, walking-zero or binary-count patterns at a
// 2^DWELL_W cycle dwell and check a loopback fixture. Monitor mode listens
// with the transceivers receiving and gathers per-pin toggle coverage.
//
//   mode | meaning
//   -----+-----------------------------------------------------------
//   0    | walk-one: each bus rotates left, seed bit0 = 1
//   1    | walk-zero: each bus rotates left, seed bit0 = 0, others 1
//   2    | count: shared counter S sliced onto each bus, seed 0
//   3    | monitor: transceivers receive, patterns hold, coverage runs
module sram_bus_tester #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 15,
  parameter int CTRL_W  = 3,
  parameter int DWELL_W = 19,
  parameter int ERR_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic              check_en,
  input  logic              clear,
  input  logic [1:0]        led_sel,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic [CTRL_W-1:0] ctrl_out,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic              trans_tx_data,
  output logic              trans_tx_addr,
  output logic              trans_n_oe,
  output logic              step,
  output logic              err_flag,
  output logic [ERR_W-1:0]  err_count,
  output logic              all_toggled,
  output logic [7:0]        LED
);

  localparam logic [1:0] MODE_WALK1 = 2'd0;
  localparam logic [1:0] MODE_WALK0 = 2'd1;
  localparam logic [1:0] MODE_COUNT = 2'd2;
  localparam logic [1:0] MODE_MON   = 2'd3;

  localparam int S_DA  = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
  localparam int S_W   = (S_DA > CTRL_W) ? S_DA : CTRL_W;
  localparam int VEC_W = DATA_W + ADDR_W + CTRL_W;
  localparam int LED_D = (DATA_W < 8) ? DATA_W : 8;
  localparam int LED_C = (CTRL_W < 3) ? CTRL_W : 3;

  localparam logic [DATA_W-1:0] DATA_SEED = DATA_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_SEED = ADDR_W'(1);
  localparam logic [CTRL_W-1:0] CTRL_SEED = CTRL_W'(1);

  logic [DWELL_W-1:0] cnt;
  logic [1:0]         mode_q;
  logic [S_W-1:0]     s_cnt;
  logic [S_W-1:0]     s_next;
  logic [VEC_W-1:0]   seen_hi, seen_lo;
  logic [VEC_W-1:0]   seen_hi_nxt, seen_lo_nxt;
  logic [VEC_W-1:0]   vec_in;
  logic               mode_chg;
  logic               dwell_done;
  logic               compare_hit;
  logic               mismatch;

  logic [DATA_W-1:0]  data_view;
  logic [ADDR_W-1:0]  addr_view;
  logic [CTRL_W-1:0]  ctrl_view;
  logic [7:0]         led_nxt;

  assign mode_chg    = (mode != mode_q);
  assign dwell_done  = (cnt == '1);
  assign s_next      = s_cnt + S_W'(1);
  assign vec_in      = {data_in, addr_in, ctrl_in};
  // The last settled cycle of a dwell is the only one compared; a mode
  // change cycle is skipped because the patterns are being reloaded.
  assign compare_hit = enable && check_en && (mode != MODE_MON) && !mode_chg && dwell_done;
  assign mismatch    = (vec_in != {data_out, addr_out, ctrl_out});

  // Dwell counter, step strobe and pattern generation; monitor mode holds patterns.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      mode_q   <= MODE_WALK1;
      s_cnt    <= '0;
      step     <= 1'b0;
      data_out <= DATA_SEED;
      addr_out <= ADDR_SEED;
      ctrl_out <= CTRL_SEED;
    end else begin
      mode_q <= mode;
      step   <= 1'b0;
      if (mode_chg) begin
        cnt   <= '0;
        s_cnt <= '0;
        case (mode)
          MODE_WALK1: begin
            data_out <= DATA_SEED;
            addr_out <= ADDR_SEED;
            ctrl_out <= CTRL_SEED;
          end
          MODE_WALK0: begin
            data_out <= ~DATA_SEED;
            addr_out <= ~ADDR_SEED;
            ctrl_out <= ~CTRL_SEED;
          end
          MODE_COUNT: begin
            data_out <= '0;
            addr_out <= '0;
            ctrl_out <= '0;
          end
          default: ;
        endcase
      end else if (enable) begin
        cnt <= cnt + DWELL_W'(1);
        if (dwell_done && (mode != MODE_MON)) begin
          step  <= 1'b1;
          s_cnt <= s_next;
          if (mode == MODE_COUNT) begin
            data_out <= s_next[DATA_W-1:0];
            addr_out <= s_next[ADDR_W-1:0];
            ctrl_out <= s_next[CTRL_W-1:0];
          end else begin
            data_out <= (data_out << 1) | (data_out >> (DATA_W - 1));
            addr_out <= (addr_out << 1) | (addr_out >> (ADDR_W - 1));
            ctrl_out <= (ctrl_out << 1) | (ctrl_out >> (CTRL_W - 1));
          end
        end
      end
    end
  end

  // Loopback error tracking; clear wins over a coincident mismatch.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_flag  <= 1'b0;
      err_count <= '0;
    end else if (clear) begin
      err_flag  <= 1'b0;
      err_count <= '0;
    end else if (compare_hit && mismatch) begin
      err_flag <= 1'b1;
      if (err_count != '1) err_count <= err_count + ERR_W'(1);
    end
  end

  // Next-state of the toggle coverage sets, so all_toggled tracks them without extra lag.
  always_comb begin
    seen_hi_nxt = seen_hi;
    seen_lo_nxt = seen_lo;
    if (clear) begin
      seen_hi_nxt = '0;
      seen_lo_nxt = '0;
    end else if (enable && (mode == MODE_MON)) begin
      seen_hi_nxt = seen_hi | vec_in;
      seen_lo_nxt = seen_lo | ~vec_in;
    end
  end

  // Coverage registers and the all-pins-toggled summary.
  always_ff @(posedge clk) begin
    if (reset) begin
      seen_hi     <= '0;
      seen_lo     <= '0;
      all_toggled <= 1'b0;
    end else begin
      seen_hi     <= seen_hi_nxt;
      seen_lo     <= seen_lo_nxt;
      all_toggled <= &(seen_hi_nxt & seen_lo_nxt);
    end
  end

  // Transceiver direction and enable follow the run/monitor request one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      trans_n_oe    <= 1'b1;
      trans_tx_data <= 1'b0;
      trans_tx_addr <= 1'b0;
    end else begin
      trans_n_oe    <= ~enable;
      trans_tx_data <= enable && (mode != MODE_MON);
      trans_tx_addr <= enable && (mode != MODE_MON);
    end
  end

  // LED view: driven patterns in drive modes, sampled pins in monitor mode.
  always_comb begin
    data_view = (mode == MODE_MON) ? data_in : data_out;
    addr_view = (mode == MODE_MON) ? addr_in : addr_out;
    ctrl_view = (mode == MODE_MON) ? ctrl_in : ctrl_out;
    led_nxt   = '0;
    case (led_sel)
      2'd0:    led_nxt = 8'(data_view[LED_D-1:0]);
      2'd1:    led_nxt = addr_view[7:0];
      2'd2:    led_nxt = 8'(addr_view[ADDR_W-1:8]);
      default: led_nxt = {err_flag, all_toggled, 3'b000, 3'(ctrl_view[LED_C-1:0])};
    endcase
  end

  // Registered LED output.
  always_ff @(posedge clk) begin
    if (reset) LED <= '0;
    else       LED <= led_nxt;
  end

endmodule

// File: tb/tb_sram_bus_tester.sv
// Randomized bench for sram_bus_tester with a step-index reference model.
module tb_sram_bus_tester;

  logic        clk = 1'b0;
  logic        reset, enable, check_en, clear;
  logic [1:0]  mode, led_sel;
  logic [7:0]  data_in;
  logic [14:0] addr_in;
  logic [2:0]  ctrl_in;

  logic [7:0]  data_out, data_out_2;
  logic [14:0] addr_out, addr_out_2;
  logic [2:0]  ctrl_out, ctrl_out_2;
  logic        trans_tx_data, trans_tx_addr, trans_n_oe, step, err_flag, all_toggled;
  logic        trans_tx_data_2, trans_tx_addr_2, trans_n_oe_2, step_2, err_flag_2, all_toggled_2;
  logic [15:0] err_count;
  logic [1:0]  err_count_2;
  logic [7:0]  LED, LED_2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sram_bus_tester #(.DWELL_W(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .check_en(check_en),
    .clear(clear), .led_sel(led_sel), .data_out(data_out), .addr_out(addr_out),
    .ctrl_out(ctrl_out), .data_in(data_in), .addr_in(addr_in), .ctrl_in(ctrl_in),
    .trans_tx_data(trans_tx_data), .trans_tx_addr(trans_tx_addr), .trans_n_oe(trans_n_oe),
    .step(step), .err_flag(err_flag), .err_count(err_count), .all_toggled(all_toggled),
    .LED(LED)
  );

  sram_bus_tester #(.DWELL_W(2), .ERR_W(2)) dut_sat (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .check_en(check_en),
    .clear(clear), .led_sel(led_sel), .data_out(data_out_2), .addr_out(addr_out_2),
    .ctrl_out(ctrl_out_2), .data_in(data_in), .addr_in(addr_in), .ctrl_in(ctrl_in),
    .trans_tx_data(trans_tx_data_2), .trans_tx_addr(trans_tx_addr_2), .trans_n_oe(trans_n_oe_2),
    .step(step_2), .err_flag(err_flag_2), .err_count(err_count_2), .all_toggled(all_toggled_2),
    .LED(LED_2)
  );

  // reference model state
  int          m_cnt, m_k;
  logic [1:0]  m_mode_q;
  logic [7:0]  m_data, m_led;
  logic [14:0] m_addr;
  logic [2:0]  m_ctrl;
  logic        m_step, m_flag, m_all, m_noe, m_tx;
  int          m_err, m_err2;
  logic [25:0] m_hi, m_lo;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Pattern for step index k of mode m, straight from the pattern rules.
  task automatic set_pats(input int m, input int k);
    if (m == 2) begin
      m_data = 8'(k);
      m_addr = 15'(k);
      m_ctrl = 3'(k);
    end else begin
      m_data = 8'(1 << (k % 8));
      m_addr = 15'(1 << (k % 15));
      m_ctrl = 3'(1 << (k % 3));
      if (m == 1) begin
        m_data = ~m_data;
        m_addr = ~m_addr;
        m_ctrl = ~m_ctrl;
      end
    end
  endtask

  task automatic model_eval();
    logic        mchg;
    logic [25:0] v, p;
    logic [7:0]  dv;
    logic [14:0] av;
    logic [2:0]  cv;
    if (reset) begin
      m_cnt = 0; m_k = 0; m_mode_q = 2'd0; set_pats(0, 0);
      m_step = 0; m_flag = 0; m_err = 0; m_err2 = 0;
      m_hi = '0; m_lo = '0; m_all = 0; m_noe = 1; m_tx = 0; m_led = '0;
    end else begin
      dv = (mode == 2'd3) ? data_in : m_data;
      av = (mode == 2'd3) ? addr_in : m_addr;
      cv = (mode == 2'd3) ? ctrl_in : m_ctrl;
      case (led_sel)
        2'd0: m_led = dv;
        2'd1: m_led = av[7:0];
        2'd2: m_led = {1'b0, av[14:8]};
        default: m_led = {m_flag, m_all, 3'b000, cv};
      endcase
      m_noe = !enable;
      m_tx  = enable && (mode != 2'd3);
      mchg  = (mode != m_mode_q);
      v = {data_in, addr_in, ctrl_in};
      p = {m_data, m_addr, m_ctrl};
      if (clear) begin
        m_flag = 0; m_err = 0; m_err2 = 0;
      end else if (!mchg && enable && check_en && mode != 2'd3 && m_cnt == 3 && v != p) begin
        m_flag = 1;
        if (m_err < 65535) m_err++;
        if (m_err2 < 3) m_err2++;
      end
      if (clear) begin
        m_hi = '0; m_lo = '0;
      end else if (enable && mode == 2'd3) begin
        m_hi = m_hi | v;
        m_lo = m_lo | ~v;
      end
      m_all  = &(m_hi & m_lo);
      m_step = 0;
      if (mchg) begin
        m_cnt = 0; m_k = 0;
        if (mode != 2'd3) set_pats(int'(mode), 0);
      end else if (enable) begin
        if (m_cnt == 3 && mode != 2'd3) begin
          m_step = 1;
          m_k++;
          set_pats(int'(mode), m_k);
        end
        m_cnt = (m_cnt + 1) % 4;
      end
      m_mode_q = mode;
    end
  endtask

  task automatic cyc();
    model_eval();
    @(posedge clk);
    #1;
    check_val("data_out", 32'(data_out), 32'(m_data));
    check_val("addr_out", 32'(addr_out), 32'(m_addr));
    check_val("ctrl_out", 32'(ctrl_out), 32'(m_ctrl));
    check_val("step", 32'(step), 32'(m_step));
    check_val("err_flag", 32'(err_flag), 32'(m_flag));
    check_val("err_count", 32'(err_count), 32'(m_err));
    check_val("err_count_sat", 32'(err_count_2), 32'(m_err2));
    check_val("all_toggled", 32'(all_toggled), 32'(m_all));
    check_val("trans", 32'({trans_tx_data, trans_tx_addr, trans_n_oe}), 32'({m_tx, m_tx, m_noe}));
    check_val("led", 32'(LED), 32'(m_led));
  endtask

  task automatic drive_loop(input logic [25:0] flip);
    {data_in, addr_in, ctrl_in} = {m_data, m_addr, m_ctrl} ^ flip;
  endtask

  task automatic drive_vec(input logic [25:0] v);
    {data_in, addr_in, ctrl_in} = v;
  endtask

  initial begin
    reset = 1; enable = 0; mode = 2'd0; check_en = 0; clear = 0; led_sel = 2'd0;
    data_in = '0; addr_in = '0; ctrl_in = '0;
    #2;
    repeat (2) cyc();
    check_val("rst_data", 32'(data_out), 32'h01);
    check_val("rst_n_oe", 32'(trans_n_oe), 32'h1);
    reset = 0;

    // walk-one with exact loopback
    enable = 1; mode = 2'd0; check_en = 1;
    for (int i = 0; i < 160; i++) begin
      led_sel = 2'($urandom_range(0, 3));
      drive_loop('0);
      cyc();
    end

    // walk-zero with exact loopback
    mode = 2'd1;
    for (int i = 0; i < 161; i++) begin
      led_sel = 2'($urandom_range(0, 3));
      drive_loop('0);
      cyc();
    end
    check_val("walk0_err_count", 32'(err_count), 32'd0);

    // count mode with data_in bit3 stuck low for 16 compares
    mode = 2'd2;
    for (int i = 0; i < 65; i++) begin
      led_sel = 2'($urandom_range(0, 3));
      drive_loop({8'h08 & m_data, 18'd0});
      cyc();
    end
    check_val("stuck3_err_count", 32'(err_count), 32'd8);
    check_val("stuck3_err_flag", 32'(err_flag), 32'd1);
    check_val("sat_err_count", 32'(err_count_2), 32'd3);
    clear = 1; drive_loop('0); cyc(); clear = 0;
    check_val("clr_err_count", 32'(err_count), 32'd0);
    check_val("clr_err_flag", 32'(err_flag), 32'd0);

    // clear coincident with a mismatching compare
    for (int i = 0; i < 4; i++) begin
      if (m_cnt != 3) begin
        drive_loop('1);
        cyc();
      end
    end
    clear = 1; drive_loop('1); cyc(); clear = 0;
    check_val("clr_vs_miss", 32'(err_count), 32'd0);
    check_val("clr_vs_miss_sat", 32'(err_count_2), 32'd0);

    // monitor mode coverage
    mode = 2'd3;
    drive_vec('0); cyc();
    repeat (3) begin drive_vec('0); cyc(); end
    repeat (3) begin drive_vec('1); cyc(); end
    check_val("mon_all_toggled", 32'(all_toggled), 32'd1);
    check_val("mon_n_oe", 32'(trans_n_oe), 32'd0);
    check_val("mon_tx", 32'({trans_tx_data, trans_tx_addr}), 32'd0);
    clear = 1; cyc(); clear = 0;
    for (int i = 0; i < 40; i++) begin
      led_sel = 2'($urandom_range(0, 3));
      drive_vec(26'($urandom) & ~(26'd1 << 8));
      cyc();
    end
    check_val("stuck_addr_toggled", 32'(all_toggled), 32'd0);

    // mode switch mid-dwell
    mode = 2'd0;
    repeat (3) begin drive_loop('0); cyc(); end
    mode = 2'd2;
    drive_loop('0); cyc();
    check_val("sw_data", 32'(data_out), 32'd0);
    check_val("sw_step", 32'(step), 32'd0);
    repeat (3) begin drive_loop('0); cyc(); end
    drive_loop('0); cyc();
    check_val("sw_first_step", 32'(step), 32'd1);
    check_val("sw_first_data", 32'(data_out), 32'd1);

    // randomized run with a mid-dwell reset
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
      enable   = ($urandom_range(0, 7) != 0);
      check_en = ($urandom_range(0, 3) != 0);
      clear    = ($urandom_range(0, 29) == 0);
      led_sel  = 2'($urandom_range(0, 3));
      if (mode == 2'd3) drive_vec(26'($urandom));
      else if ($urandom_range(0, 9) == 0) drive_loop(26'd1 << $urandom_range(0, 25));
      else drive_loop('0);
      reset = (i == 300);
      cyc();
      if (i == 300) begin
        check_val("midrst_data", 32'(data_out), 32'h01);
        check_val("midrst_err", 32'(err_count), 32'd0);
        check_val("midrst_led", 32'(LED), 32'd0);
      end
    end
    reset = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
